// File: rtl/alarm_controller.sv
// alarm_controller: alarm master FSM (IDLE -> SET -> TRIGGER -> ALERT) with input synchronisers
// and a once-per-second entry-delay countdown. Define ALARM_AUTO_REARM_EN to auto-rearm after ALERT_SECONDS.
package alarm_pkg;
    typedef enum logic [1:0] {
        STATE_IDLE    = 2'd0,
        STATE_SET     = 2'd1,
        STATE_TRIGGER = 2'd2,
        STATE_ALERT   = 2'd3
    } fsm_state_t;
endpackage

module alarm_controller
    import alarm_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned TRIGGER_SECONDS = 30,
    parameter int unsigned ALERT_SECONDS   = 60
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       arm_btn,
    input  logic       disarm_btn,
    input  logic       sensor,
    output fsm_state_t system_state,
    output logic [0:7] timer,
    output logic       alarm_out
);

    localparam int unsigned PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);
    localparam logic [7:0] TIMER_LOAD = 8'(TRIGGER_SECONDS);

    if (CLK_HZ < 1 || TRIGGER_SECONDS < 1 || TRIGGER_SECONDS > 99 || ALERT_SECONDS < 1) begin : g_bad_params
        $error("alarm_controller: parameter out of range");
    end

    // Buttons: two synchroniser flops plus a third for rising-edge detection.
    logic [1:0] btn_async;
    logic [1:0] btn_req;
    logic       arm_req;
    logic       disarm_req;

    assign btn_async = {disarm_btn, arm_btn};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn_sync
        logic [2:0] pipe_reg;
        always_ff @(posedge clock) begin
            if (reset) begin
                pipe_reg <= '0;
            end else begin
                pipe_reg <= {pipe_reg[1:0], btn_async[gi]};
            end
        end
        assign btn_req[gi] = pipe_reg[1] & ~pipe_reg[2];
    end

    assign arm_req    = btn_req[0];
    assign disarm_req = btn_req[1];

    logic [1:0] sensor_pipe_reg;
    logic       sensor_lvl;

    always_ff @(posedge clock) begin
        if (reset) begin
            sensor_pipe_reg <= '0;
        end else begin
            sensor_pipe_reg <= {sensor_pipe_reg[0], sensor};
        end
    end

    assign sensor_lvl = sensor_pipe_reg[1];

    fsm_state_t         state_reg, state_next;
    logic [7:0]         timer_reg, timer_next;
    logic               alarm_reg;
    logic [PRESC_W-1:0] presc_reg, presc_next;
    logic               tick;
    logic               entering_timed;

    assign tick = (presc_reg == PRESC_MAX);

`ifdef ALARM_AUTO_REARM_EN
    localparam int unsigned ALERT_W = (ALERT_SECONDS > 1) ? $clog2(ALERT_SECONDS) : 1;
    localparam logic [ALERT_W-1:0] ALERT_LAST = ALERT_W'(ALERT_SECONDS - 1);
    logic [ALERT_W-1:0] alert_cnt_reg, alert_cnt_next;
`endif

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
`ifdef ALARM_AUTO_REARM_EN
        alert_cnt_next = alert_cnt_reg;
`endif
        case (state_reg)
            STATE_IDLE: begin
                if (arm_req) begin
                    state_next = STATE_SET;
                end
            end
            STATE_SET: begin
                if (disarm_req) begin
                    state_next = STATE_IDLE;
                end else if (sensor_lvl) begin
                    state_next = STATE_TRIGGER;
                    timer_next = TIMER_LOAD;
                end
            end
            STATE_TRIGGER: begin
                // Disarm wins even when it coincides with the final tick.
                if (disarm_req) begin
                    state_next = STATE_IDLE;
                end else if (tick) begin
                    if (timer_reg > 8'd1) begin
                        timer_next = timer_reg - 8'd1;
                    end else begin
                        state_next = STATE_ALERT;
                    end
                end
            end
            STATE_ALERT: begin
                if (disarm_req) begin
                    state_next = STATE_IDLE;
                end
`ifdef ALARM_AUTO_REARM_EN
                else if (tick) begin
                    if (alert_cnt_reg == ALERT_LAST) begin
                        state_next = STATE_SET;
                    end else begin
                        alert_cnt_next = alert_cnt_reg + 1'b1;
                    end
                end
`endif
            end
            default: begin
                state_next = STATE_IDLE;
            end
        endcase

        if (state_next != STATE_TRIGGER) begin
            timer_next = '0;
        end

`ifdef ALARM_AUTO_REARM_EN
        if (state_next == STATE_ALERT && state_reg != STATE_ALERT) begin
            alert_cnt_next = '0;
        end
`endif

        // Restarting the prescaler on entry makes the first tick land exactly CLK_HZ cycles later.
        entering_timed = (state_next != state_reg) &&
                         (state_next == STATE_TRIGGER || state_next == STATE_ALERT);
        if (entering_timed || tick) begin
            presc_next = '0;
        end else begin
            presc_next = presc_reg + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= STATE_IDLE;
            timer_reg <= '0;
            alarm_reg <= 1'b0;
            presc_reg <= '0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            alarm_reg <= (state_next == STATE_ALERT);
            presc_reg <= presc_next;
        end
    end

`ifdef ALARM_AUTO_REARM_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            alert_cnt_reg <= '0;
        end else begin
            alert_cnt_reg <= alert_cnt_next;
        end
    end
`endif

    assign system_state = state_reg;
    assign timer        = timer_reg;
    assign alarm_out    = alarm_reg;

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Upstream producer of `system_state` and `timer` for the VGA display stage: the alarm system's master state machine. It synchronises the arm, disarm and sensor inputs, sequences IDLE → SET → TRIGGER → ALERT, and runs the 1 Hz entry-delay countdown shown on screen. It runs on the 50 MHz board clock and drives the display's state and timer inputs directly, with no further registering required.

## Interface
- `CLK_HZ`, default 50_000_000: clock cycles per countdown second; benches override it with a small value.
- `TRIGGER_SECONDS`, default 30: countdown start value; legal range 1..99 (two on-screen digits).
- `ALERT_SECONDS`, default 60: ALERT duration before auto-rearm; used only when `ALARM_AUTO_REARM_EN` is defined.
- `clock` input 1: 50 MHz system clock. All logic is on its rising edge.
- `reset` input 1: synchronous, active-high.
- `arm_btn` input 1: asynchronous pushbutton, active-high. A rising edge is an arm request.
- `disarm_btn` input 1: asynchronous pushbutton, active-high. A rising edge is a disarm request.
- `sensor` input 1: asynchronous intrusion sensor, active-high, level-sensitive.
- `system_state` output `fsm_state_t`: one of STATE_IDLE, STATE_SET, STATE_TRIGGER, STATE_ALERT.
- `timer` output [0:7]: remaining countdown seconds as unsigned binary, bit 0 MSB.
- `alarm_out` output 1: siren drive; high exactly while in STATE_ALERT.

## Operation
- **Input synchronisers.** Each asynchronous input passes through a 2-flop synchroniser.
  - `arm_btn` and `disarm_btn` get a third flop for rising-edge detection, producing single-cycle pulses `arm_req` and `disarm_req`.
  - `sensor` is used as a synchronised level.
- **Prescaler.** Counts 0..CLK_HZ-1 and emits a one-cycle `tick` when it holds CLK_HZ-1.
  - It is forced to 0 on every cycle the FSM enters TRIGGER or ALERT.
- **State transitions.**
  - IDLE: `arm_req` → SET. `sensor` is ignored.
  - SET: `disarm_req` → IDLE. Otherwise, `sensor` high → TRIGGER, with `timer` loaded with TRIGGER_SECONDS.
  - TRIGGER: `disarm_req` → IDLE, with `timer` set to 0. Otherwise, on `tick`: if `timer` > 1, decrement it; if `timer` == 1, set `timer` to 0 and move to ALERT in the same cycle.
  - ALERT: `disarm_req` → IDLE. The alert is otherwise latched; see Configuration.
- **Timer value.**
  - `timer` is 0 in every state except TRIGGER.
  - It never wraps below 0 and never exceeds TRIGGER_SECONDS.
- **Simultaneous events.**
  - Disarm has priority over sensor in SET.
  - Disarm has priority over the final tick in TRIGGER: the FSM goes to IDLE, not ALERT.
  - `arm_req` is ignored in every state except IDLE.
  - A sensor level that stays high after disarm and re-arm re-triggers on the first cycle in SET.

## Timing
- **Reset** (takes effect on the rising edge where `reset` = 1). It overrides every other input.
  - `system_state` = STATE_IDLE, `timer` = 0, `alarm_out` = 0.
  - The prescaler, synchronisers and edge flops are cleared.
  - Asserting reset mid-countdown or mid-alert returns to IDLE on that edge.
- **Input latency.** An input asserted before clock edge N, with setup met, changes `system_state` on edge N+2.
- **Countdown timing.**
  - The first decrement occurs exactly CLK_HZ cycles after the edge that enters TRIGGER.
  - Later decrements follow every CLK_HZ cycles.
  - TRIGGER → ALERT therefore occurs exactly TRIGGER_SECONDS × CLK_HZ cycles after entry.
- **Output registering.** All outputs are registered, with no combinational path from the inputs.
  - `alarm_out` changes on the same edge as `system_state`.

## Configuration
- `ALARM_AUTO_REARM_EN` defined:
  - In ALERT, an internal seconds counter clears on entry and increments on each `tick`.
  - After ALERT_SECONDS ticks the FSM returns to SET, with `alarm_out` falling on that edge and `timer` staying 0.
  - `disarm_req` still takes priority and goes to IDLE.
- `ALARM_AUTO_REARM_EN` undefined:
  - ALERT holds until `disarm_req` or `reset`.
  - The ALERT seconds counter is not synthesised.

## Test plan
All scenarios use CLK_HZ=10, TRIGGER_SECONDS=5 and ALERT_SECONDS=3.
- **Reset:** hold `reset` for 2 cycles with random inputs → IDLE, `timer`=0, `alarm_out`=0; `sensor` high in IDLE → stays IDLE.
- **Full countdown:** arm, then sensor pulse → TRIGGER with `timer`=5. `timer` reads 4, 3, 2, 1 at entry+10/20/30/40 cycles. At entry+50, state becomes ALERT with `timer`=0 and `alarm_out`=1.
- **Disarm mid-countdown:** disarm at `timer`=3 → IDLE two edges later, `timer`=0; a later sensor pulse has no effect.
- **Simultaneous final tick and disarm:** `disarm_req` lands on the same cycle as the tick at `timer`=1 → IDLE, `alarm_out` never asserts.
- **Held button:** `arm_btn` held high for 100 cycles → exactly one IDLE→SET transition; disarm and re-press arm → SET again.
- **Alert exit:** with `ALARM_AUTO_REARM_EN`, ALERT → SET exactly 30 cycles after ALERT entry. Without it, ALERT still holds at 1000 cycles and goes to IDLE on disarm.
